bip_control: RTL and testbench

- Control unit for the BIP accumulator processor. It fetches the instruction at the program counter, decodes the 5-bit opcode and drives the accumulator datapath's select, write and op-code controls plus the data-memory strobes.
- It updates on posedge i_clk. The datapath and data memory capture on the following negedge of the same cycle.
- It sits between program memory and the datapath/data-memory pair.

---
 rtl/bip_control.sv | 147 ++++++++++++++
 tb/tb_bip_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP accumulator-processor control unit: fetch at PC, decode opcode, drive datapath/RAM strobes.
// Optional cycle counter output o_cycles enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control #(
    parameter int unsigned NB_BITS   = 16,
    parameter int unsigned NB_OPCODE = 5,
    parameter int unsigned NB_ADDR   = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_BITS-1:0] i_instr,
    output logic [NB_ADDR-1:0] o_addr_prog,
    output logic [NB_ADDR-1:0] o_addr_data,
    output logic [NB_ADDR-1:0] o_data_ins,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_op_code,
    output logic               o_wr_acc,
    output logic               o_wr_ram,
    output logic               o_rd_ram,
    output logic               o_halted,
    output logic               o_illegal
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [31:0]        o_cycles
`endif
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               state_q;
    logic [NB_ADDR-1:0]   pc_q;
    logic                 halted_q;
    logic                 illegal_q;
    logic [NB_OPCODE-1:0] opcode;
    logic                 op_legal;

    assign opcode      = i_instr[NB_BITS-1 -: NB_OPCODE];
    assign op_legal    = (opcode <= OP_SUBI);
    assign o_addr_prog = pc_q;
    assign o_addr_data = i_instr[NB_ADDR-1:0];
    assign o_data_ins  = i_instr[NB_ADDR-1:0];
    assign o_halted    = halted_q;
    assign o_illegal   = illegal_q;

    // Sequencer: PC wraps naturally at 2^NB_ADDR; HLT freezes PC at its own address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (opcode == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_q + NB_ADDR'(1);
                        if (!op_legal) illegal_q <= 1'b1;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Instruction decode; every control is held low outside RUN.
    always_comb begin
        o_sel_a   = 2'b00;
        o_sel_b   = 1'b0;
        o_op_code = 1'b0;
        o_wr_acc  = 1'b0;
        o_wr_ram  = 1'b0;
        o_rd_ram  = 1'b0;
        if (state_q == ST_RUN) begin
            case (opcode)
                OP_STO: o_wr_ram = 1'b1;
                OP_LD: begin
                    o_wr_acc = 1'b1;
                    o_rd_ram = 1'b1;
                end
                OP_LDI: begin
                    o_wr_acc = 1'b1;
                    o_sel_a  = 2'b01;
                end
                OP_ADD: begin
                    o_wr_acc  = 1'b1;
                    o_sel_a   = 2'b10;
                    o_op_code = 1'b1;
                    o_rd_ram  = 1'b1;
                end
                OP_ADDI: begin
                    o_wr_acc  = 1'b1;
                    o_sel_a   = 2'b10;
                    o_sel_b   = 1'b1;
                    o_op_code = 1'b1;
                end
                OP_SUB: begin
                    o_wr_acc = 1'b1;
                    o_sel_a  = 2'b10;
                    o_rd_ram = 1'b1;
                end
                OP_SUBI: begin
                    o_wr_acc = 1'b1;
                    o_sel_a  = 2'b10;
                    o_sel_b  = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    // Execution-time counter: counts RUN cycles including the HLT cycle, saturating.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycles_q <= '0;
        end else if (state_q == ST_RUN && cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Randomized and directed bench for bip_control against a table-driven behavioural model.
module tb_bip_control;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_instr;
    logic [10:0] o_addr_prog;
    logic [10:0] o_addr_data;
    logic [10:0] o_data_ins;
    logic [1:0]  o_sel_a;
    logic        o_sel_b;
    logic        o_op_code;
    logic        o_wr_acc;
    logic        o_wr_ram;
    logic        o_rd_ram;
    logic        o_halted;
    logic        o_illegal;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] o_cycles;
`endif

    logic [15:0] prog [2048];
    assign i_instr = prog[o_addr_prog];

    bip_control dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_instr     (i_instr),
        .o_addr_prog (o_addr_prog),
        .o_addr_data (o_addr_data),
        .o_data_ins  (o_data_ins),
        .o_sel_a     (o_sel_a),
        .o_sel_b     (o_sel_b),
        .o_op_code   (o_op_code),
        .o_wr_acc    (o_wr_acc),
        .o_wr_ram    (o_wr_ram),
        .o_rd_ram    (o_rd_ram),
        .o_halted    (o_halted),
        .o_illegal   (o_illegal)
`ifdef BIP_CYCLE_COUNT_EN
        ,
        .o_cycles    (o_cycles)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Controls per legal opcode: {wr_acc, sel_a[1:0], sel_b, op_code, wr_ram, rd_ram}.
    logic [6:0] tab [8];
    initial begin
        tab[0] = 7'b0_00_0_0_0_0;
        tab[1] = 7'b0_00_0_0_1_0;
        tab[2] = 7'b1_00_0_0_0_1;
        tab[3] = 7'b1_01_0_0_0_0;
        tab[4] = 7'b1_10_0_1_0_1;
        tab[5] = 7'b1_10_1_1_0_0;
        tab[6] = 7'b1_10_0_0_0_1;
        tab[7] = 7'b1_10_1_0_0_0;
    end

    // Behavioural model: 0 = idle, 1 = run, 2 = halt.
    int          m_st  = 0;
    int          m_pc  = 0;
    bit          m_ill = 1'b0;
    logic [31:0] m_cyc = 32'd0;

    always @(posedge i_clk) begin
        int op;
        op = int'(prog[m_pc][15:11]);
        if (i_rst) begin
            m_st = 0; m_pc = 0; m_ill = 1'b0; m_cyc = 32'd0;
        end else if (m_st == 0) begin
            if (i_start) m_st = 1;
        end else if (m_st == 1) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
            if (op == 0) m_st = 2;
            else begin
                if (op > 7) m_ill = 1'b1;
                m_pc = (m_pc + 1) % 2048;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        int op;
        logic [6:0] ectl, actl;
        logic [15:0] ins;
        if (chk_en) begin
            ins  = prog[m_pc];
            op   = int'(ins[15:11]);
            ectl = (m_st == 1 && op < 8) ? tab[op] : 7'd0;
            actl = {o_wr_acc, o_sel_a, o_sel_b, o_op_code, o_wr_ram, o_rd_ram};
            n_tests++;
            if (actl !== ectl || o_addr_prog !== 11'(m_pc) || o_addr_data !== ins[10:0] ||
                o_data_ins !== ins[10:0] || o_halted !== (m_st == 2) || o_illegal !== m_ill) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t ctl=%b/%b pc=%0d/%0d adr=%0h/%0h imm=%0h halt=%b/%0d ill=%b/%b",
                         $time, actl, ectl, o_addr_prog, m_pc, o_addr_data, ins[10:0], o_data_ins,
                         o_halted, m_st == 2, o_illegal, m_ill);
            end
`ifdef BIP_CYCLE_COUNT_EN
            n_tests++;
            if (o_cycles !== m_cyc) begin
                n_fail++;
                $display("FAIL model_cycles t=%0t got %0d expected %0d", $time, o_cycles, m_cyc);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit start);
        i_rst   = rst;
        i_start = start;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input int op, input int arg);
        return {5'(op), 11'(arg)};
    endfunction

    task automatic clear_prog(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) prog[i] = w;
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        clear_prog(16'h0000);
        prog[0] = ins(3, 5);
        prog[1] = ins(5, 3);
        prog[2] = ins(0, 0);
        tick(1, 0);
        chk_en = 1'b1;
        tick(1, 0);
        chk("rst_pc", 32'(o_addr_prog), 0);
        chk("rst_halted", 32'(o_halted), 0);
        chk("rst_sel_a", 32'(o_sel_a), 0);
        chk("idle_wr_acc", 32'(o_wr_acc), 0);

        // LDI 5, ADDI 3, HLT
        tick(0, 1);
        chk("ldi_wr_acc", 32'(o_wr_acc), 1);
        chk("ldi_sel_a", 32'(o_sel_a), 1);
        chk("ldi_imm", 32'(o_data_ins), 5);
        tick(0, 0);
        chk("addi_ctl", 32'({o_sel_a, o_sel_b, o_op_code}), 32'b10_1_1);
        tick(0, 0);
        chk("hlt_strobes", 32'({o_wr_acc, o_wr_ram, o_rd_ram}), 0);
        chk("hlt_halted_pre", 32'(o_halted), 0);
        tick(0, 0);
        chk("halt_halted", 32'(o_halted), 1);
        chk("halt_pc", 32'(o_addr_prog), 2);
`ifdef BIP_CYCLE_COUNT_EN
        chk("halt_cycles", o_cycles, 3);
`endif
        tick(0, 1);
        tick(0, 0);
        chk("halt_start_halted", 32'(o_halted), 1);
        chk("halt_start_pc", 32'(o_addr_prog), 2);
`ifdef BIP_CYCLE_COUNT_EN
        chk("halt_start_cycles", o_cycles, 3);
`endif

        // LD 7, SUB 8, STO 9, HLT
        clear_prog(16'h0000);
        prog[0] = ins(2, 7);
        prog[1] = ins(6, 8);
        prog[2] = ins(1, 9);
        tick(1, 0);
        tick(0, 1);
        chk("ld_ctl", 32'({o_rd_ram, o_sel_a, o_wr_acc}), 32'b1_00_1);
        chk("ld_addr", 32'(o_addr_data), 7);
        tick(0, 0);
        chk("sub_ctl", 32'({o_rd_ram, o_sel_b, o_op_code, o_sel_a}), 32'b1_0_0_10);
        tick(0, 0);
        chk("sto_ctl", 32'({o_wr_ram, o_wr_acc, o_rd_ram}), 32'b1_0_0);
        chk("sto_addr", 32'(o_addr_data), 9);
        tick(0, 0);

        // Illegal opcode then HLT
        clear_prog(16'h0000);
        prog[0] = ins(31, 0);
        tick(1, 0);
        tick(0, 1);
        chk("ill_strobes", 32'({o_wr_acc, o_wr_ram, o_rd_ram, o_sel_a}), 0);
        chk("ill_pre", 32'(o_illegal), 0);
        tick(0, 0);
        chk("ill_pc", 32'(o_addr_prog), 1);
        chk("ill_set", 32'(o_illegal), 1);
        tick(0, 0);
        chk("ill_halt_sticky", 32'({o_halted, o_illegal}), 32'b11);
        tick(1, 0);
        chk("ill_rst_clear", 32'(o_illegal), 0);

        // PC wrap with an LDI-filled program
        clear_prog(ins(3, 0));
        tick(1, 0);
        tick(0, 1);
        for (int i = 0; i < 2047; i++) tick(0, 0);
        chk("wrap_pc_max", 32'(o_addr_prog), 2047);
        tick(0, 0);
        chk("wrap_pc_zero", 32'(o_addr_prog), 0);
        tick(0, 0);
        chk("wrap_continue", 32'({o_addr_prog, o_halted}), 32'({11'd1, 1'b0}));

        // Reset mid-RUN at PC 4
        tick(1, 0);
        tick(0, 1);
        for (int i = 0; i < 4; i++) tick(0, 0);
        chk("mid_pc4", 32'(o_addr_prog), 4);
        tick(1, 0);
        chk("mid_rst", 32'({o_addr_prog, o_wr_acc, o_halted}), 0);
        for (int i = 0; i < 3; i++) tick(0, 0);
        chk("mid_idle_hold", 32'({o_addr_prog, o_wr_acc}), 0);
        tick(0, 1);
        chk("mid_resume", 32'({o_addr_prog, o_wr_acc}), 32'({11'd0, 1'b1}));
        tick(0, 0);
        chk("mid_resume_pc", 32'(o_addr_prog), 1);

        // Randomized programs, start pulses and resets checked by the model
        for (int p = 0; p < 8; p++) begin
            clear_prog(16'h0000);
            for (int a = 0; a < 200; a++) begin
                int r, op;
                r = int'($urandom_range(0, 99));
                if (r < 3) op = 0;
                else if (r < 10) op = int'($urandom_range(8, 31));
                else op = int'($urandom_range(1, 7));
                prog[a] = ins(op, int'($urandom_range(0, 2047)));
            end
            tick(1, 0);
            for (int c = 0; c < 150; c++)
                tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
